// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD (double-dabble) converter with start/busy/done handshake.
// Latency: result and done pulse visible WORD_LENGTH+1 cycles after the accepting edge.
// Backpressure: none queued; start is ignored while busy, so the issuer must wait for done.
//
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   start, bin        - conversion request and two's-complement operand (sampled in IDLE)
//   busy              - conversion in progress (registered state decode)
//   done              - one-cycle pulse when H/T/U/sign are updated
//   H, T, U, sign     - hundreds/tens/units BCD digits, sign (1 = non-negative)
module bin2bcd_seq_ctrl #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_LENGTH-1:0] bin,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             H,
    output logic [3:0]             T,
    output logic [3:0]             U,
    output logic                   sign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [WORD_LENGTH-1:0]     mag;
    logic [WORD_LENGTH-1:0]     mag_in;
    logic [11:0]                scratch;
    logic [11:0]                adj;
    logic [3:0]                 cnt;
    logic                       sign_next;
    logic [11+WORD_LENGTH:0]    shifted;

    // Magnitude in WORD_LENGTH bits; the most-negative operand maps to 2^(WORD_LENGTH-1)
    // when read as unsigned, which still fits the three-digit scratch.
    assign mag_in = bin[WORD_LENGTH-1] ? (~bin + WORD_LENGTH'(1)) : bin;

    // Add-3 correction on the pre-shift nibbles, all three in parallel.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // One combined shift moves the magnitude MSB into scratch bit 0.
    assign shifted = {adj, mag} << 1;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SHIFT;
            // cnt==1 here means this edge performs the final iteration.
            SHIFT:   if (cnt == 4'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag       <= '0;
            scratch   <= '0;
            cnt       <= '0;
            sign_next <= 1'b1;
            H         <= '0;
            T         <= '0;
            U         <= '0;
            sign      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mag       <= mag_in;
                        sign_next <= ~bin[WORD_LENGTH-1];
                        scratch   <= '0;
                        cnt       <= 4'(WORD_LENGTH);
                    end
                end
                SHIFT: begin
                    scratch <= shifted[11+WORD_LENGTH:WORD_LENGTH];
                    mag     <= shifted[WORD_LENGTH-1:0];
                    cnt     <= cnt - 4'd1;
                end
                DONE: begin
                    // Outputs are only ever loaded here, so intermediate scratch stays hidden.
                    H    <= scratch[11:8];
                    T    <= scratch[7:4];
                    U    <= scratch[3:0];
                    sign <= sign_next;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Self-checking bench for bin2bcd_seq_ctrl: directed scenarios on an 8-bit instance,
// exhaustive operand sweeps on 8-bit and 10-bit instances.
module tb_bin2bcd_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] bin8 = '0;
    logic       busy8, done8, sign8;
    logic [3:0] h8, t8, u8;
    logic       start10 = 1'b0;
    logic [9:0] bin10 = '0;
    logic       busy10, done10, sign10;
    logic [3:0] h10, t10, u10;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_ctrl #(.WORD_LENGTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .H(h8), .T(t8), .U(u8), .sign(sign8)
    );

    bin2bcd_seq_ctrl #(.WORD_LENGTH(10)) dut10 (
        .clk(clk), .reset(reset), .start(start10), .bin(bin10),
        .busy(busy10), .done(done10), .H(h10), .T(t10), .U(u10), .sign(sign10)
    );

    // Decimal reference: {H, T, U, sign} for magnitude m.
    function automatic logic [12:0] dec_model(input int m, input logic s);
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10), s};
    endfunction

    // Issue one conversion on the 8-bit DUT; lat = cycles from accepting edge to done, -1 on timeout.
    task automatic run8(input logic [7:0] b, output int lat);
        @(negedge clk);
        bin8   = b;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        bin8   = ~b;
        lat    = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run10(input logic [9:0] b, output int lat);
        @(negedge clk);
        bin10   = b;
        start10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        bin10   = ~b;
        lat     = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done10) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({busy8, done8} !== 2'b00) begin
            fails++;
            $display("FAIL reset_busy_done: got %b required 00", {busy8, done8});
        end
        tests++;
        if ({h8, t8, u8, sign8} !== 13'h0001) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0001", {h8, t8, u8, sign8});
        end
        tests++;
        if ({busy10, done10, h10, t10, u10, sign10} !== 15'h0001) begin
            fails++;
            $display("FAIL reset_outputs10: got %h required 0001", {busy10, done10, h10, t10, u10, sign10});
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if ({busy8, done8} !== 2'b00) begin
                fails++;
                $display("FAIL idle_no_done: cycle %0d got %b required 00", i, {busy8, done8});
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [12:0] res;
        run8(8'd127, lat);
        tests++;
        if (lat !== 9) begin
            fails++;
            $display("FAIL basic_latency: got %0d required 9", lat);
        end
        res = {h8, t8, u8, sign8};
        tests++;
        if (res !== {4'd1, 4'd2, 4'd7, 1'b1}) begin
            fails++;
            $display("FAIL basic_result: got %h required %h", res, {4'd1, 4'd2, 4'd7, 1'b1});
        end
        tests++;
        if (busy8 !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy_in_done: got %b required 0", busy8);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if ({done8, busy8, h8, t8, u8, sign8} !== {2'b00, res}) begin
                fails++;
                $display("FAIL basic_hold: cycle %0d got %h required %h", i,
                         {done8, busy8, h8, t8, u8, sign8}, {2'b00, res});
            end
        end
    endtask

    task automatic test_negative();
        logic [7:0]  vb [4] = '{8'h80, 8'hFF, 8'h00, 8'h81};
        logic [12:0] ve [4] = '{{4'd1, 4'd2, 4'd8, 1'b0}, {4'd0, 4'd0, 4'd1, 1'b0},
                                {4'd0, 4'd0, 4'd0, 1'b1}, {4'd1, 4'd2, 4'd7, 1'b0}};
        int lat;
        for (int k = 0; k < 4; k++) begin
            run8(vb[k], lat);
            tests++;
            if (lat !== 9 || {h8, t8, u8, sign8} !== ve[k]) begin
                fails++;
                $display("FAIL negative_%h: got lat %0d res %h required lat 9 res %h",
                         vb[k], lat, {h8, t8, u8, sign8}, ve[k]);
            end
        end
    endtask

    task automatic test_busy_protect();
        int ndone = 0;
        int first = -1;
        int second = -1;
        logic [12:0] res1 = '0;
        logic [12:0] res2 = '0;
        @(negedge clk);
        bin8   = 8'd99;
        start8 = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            start8 = 1'b0;
            if (done8) begin
                ndone++;
                if (ndone == 1) begin
                    first  = c;
                    res1   = {h8, t8, u8, sign8};
                    start8 = 1'b1;
                    bin8   = 8'd5;
                end else begin
                    second = c;
                    res2   = {h8, t8, u8, sign8};
                end
            end
            if (c == 3 || c == 8) begin
                start8 = 1'b1;
                bin8   = 8'd5;
            end
            if (c < 9) begin
                tests++;
                if (busy8 !== 1'b1) begin
                    fails++;
                    $display("FAIL busy_high: cycle %0d got %b required 1", c, busy8);
                end
            end
        end
        tests++;
        if (ndone !== 2 || first !== 9 || second !== 19) begin
            fails++;
            $display("FAIL busy_done_timing: got count %0d at %0d,%0d required 2 at 9,19",
                     ndone, first, second);
        end
        tests++;
        if (res1 !== {4'd0, 4'd9, 4'd9, 1'b1}) begin
            fails++;
            $display("FAIL busy_result1: got %h required %h", res1, {4'd0, 4'd9, 4'd9, 1'b1});
        end
        tests++;
        if (res2 !== {4'd0, 4'd0, 4'd5, 1'b1}) begin
            fails++;
            $display("FAIL busy_result2: got %h required %h", res2, {4'd0, 4'd0, 4'd5, 1'b1});
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        @(negedge clk);
        bin8   = 8'd200;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({busy8, done8, h8, t8, u8, sign8} !== 15'h0001) begin
            fails++;
            $display("FAIL async_reset: got %h required 0001", {busy8, done8, h8, t8, u8, sign8});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if ({done8, busy8, h8, t8, u8, sign8} !== 15'h0001) begin
                fails++;
                $display("FAIL after_reset_quiet: cycle %0d got %h required 0001", i,
                         {done8, busy8, h8, t8, u8, sign8});
            end
        end
        run8(8'd42, lat);
        tests++;
        if (lat !== 9 || {h8, t8, u8, sign8} !== {4'd0, 4'd4, 4'd2, 1'b1}) begin
            fails++;
            $display("FAIL after_reset_conv: got lat %0d res %h required lat 9 res %h",
                     lat, {h8, t8, u8, sign8}, {4'd0, 4'd4, 4'd2, 1'b1});
        end
    endtask

    task automatic test_sweep8();
        int lat;
        int m;
        logic [12:0] exp_v;
        for (int v = 0; v < 256; v++) begin
            m     = (v >= 128) ? 256 - v : v;
            exp_v = dec_model(m, v < 128);
            run8(8'(v), lat);
            tests++;
            if (lat !== 9 || {h8, t8, u8, sign8} !== exp_v) begin
                fails++;
                $display("FAIL sweep8 bin=%0d: got lat %0d res %h required lat 9 res %h",
                         v, lat, {h8, t8, u8, sign8}, exp_v);
            end
        end
    endtask

    task automatic test_sweep10();
        int lat;
        int m;
        logic [12:0] exp_v;
        for (int v = 0; v < 1024; v++) begin
            m     = (v >= 512) ? 1024 - v : v;
            exp_v = dec_model(m, v < 512);
            run10(10'(v), lat);
            tests++;
            if (lat !== 11 || {h10, t10, u10, sign10} !== exp_v) begin
                fails++;
                $display("FAIL sweep10 bin=%0d: got lat %0d res %h required lat 11 res %h",
                         v, lat, {h10, t10, u10, sign10}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_busy_protect();
        test_mid_reset();
        test_sweep8();
        test_sweep10();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
